// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared state encoding and default timing for the button event decoder
package btn_event_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HELD   = 3'd1;
    localparam logic [2:0] ST_LONG   = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_SECOND = 3'd4;

    localparam int DEFAULT_LONG_CYCLES = 8;
    localparam int DEFAULT_GAP_CYCLES  = 6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        HELD   = ST_HELD,
        LONG   = ST_LONG,
        GAP    = ST_GAP,
        SECOND = ST_SECOND
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - registers a pressed level once and derives its rise/fall edges
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic r_lvl_q;

    // Reset to not-pressed so a button held through reset yields a press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_q <= 1'b0;
        end else begin
            r_lvl_q <= level;
        end
    end

    assign rise = level & ~r_lvl_q;
    assign fall = ~level & r_lvl_q;

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies a debounced button into press/release, click, double-click and long-press pulses
module button_event_decoder
    import btn_event_pkg::*;
#(
    parameter int LONG_CYCLES  = DEFAULT_LONG_CYCLES,
    parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
    parameter bit ACTIVE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       debounced,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       single_click,
    output logic       double_click,
    output logic       long_press,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(max_int(LONG_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             w_pressed;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_single;
    logic             r_double;
    logic             r_long;

    assign w_pressed = (debounced == ACTIVE_LEVEL);

    btn_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (w_pressed),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Release is tested before the threshold in HELD, press before expiry in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_single  <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_single  <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_cnt     <= w_cnt_inc;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_press <= 1'b1;
                        r_state <= HELD;
                    end
                end
                HELD: begin
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= GAP;
                    end else if (r_cnt == LONG_LAST) begin
                        r_long  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= LONG;
                    end
                end
                LONG: begin
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                GAP: begin
                    if (w_rise) begin
                        r_press  <= 1'b1;
                        r_double <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= SECOND;
                    end else if (r_cnt == GAP_LAST) begin
                        r_single <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= IDLE;
                    end
                end
                SECOND: begin
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign single_click  = r_single;
    assign double_click  = r_double;
    assign long_press    = r_long;
    assign state_dbg     = r_state;

endmodule
